// File: rtl/i2s_audio_rx.sv
// I2S receiver: oversamples the codec's BCLK/LRCK/SDATA in the system clock domain
// and presents one MSB-aligned signed stereo pair per frame with a one-cycle strobe.
module i2s_audio_rx #(
    parameter int SAMPLE_BITS = 24
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i2s_bclk,
    input  logic        i2s_lrck,
    input  logic        i2s_sdata,
    output logic [31:0] audio_out_L,
    output logic [31:0] audio_out_R,
    output logic        audio_valid,
    output logic        frame_error
);

    typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

    state_t      state;
    logic        bclk_s1, bclk_s2, bclk_s3;
    logic        lrck_s1, lrck_s2;
    logic        sdata_s1, sdata_s2;
    logic        bit_ev, ev_lr, ev_sd;
    logic        lr_q, lr_valid, prev_ch;
    logic [31:0] shift_reg, hold_l;
    logic [5:0]  bit_cnt;
    logic [4:0]  bit_pos;
    logic        bad_count;

    assign bit_pos   = 5'd31 - bit_cnt[4:0];
    assign bad_count = (bit_cnt != 6'(SAMPLE_BITS));

    // Synchronizers plus a registered edge detect; lrck/sdata are captured
    // from the same stage as bclk so each bit event sees a coherent sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bclk_s1  <= 1'b0;
            bclk_s2  <= 1'b0;
            bclk_s3  <= 1'b0;
            lrck_s1  <= 1'b0;
            lrck_s2  <= 1'b0;
            sdata_s1 <= 1'b0;
            sdata_s2 <= 1'b0;
            bit_ev   <= 1'b0;
            ev_lr    <= 1'b0;
            ev_sd    <= 1'b0;
        end else begin
            bclk_s1  <= i2s_bclk;
            bclk_s2  <= bclk_s1;
            bclk_s3  <= bclk_s2;
            lrck_s1  <= i2s_lrck;
            lrck_s2  <= lrck_s1;
            sdata_s1 <= i2s_sdata;
            sdata_s2 <= sdata_s1;
            bit_ev   <= bclk_s2 & ~bclk_s3;
            ev_lr    <= lrck_s2;
            ev_sd    <= sdata_s2;
        end
    end

    // lr_valid masks the first bit event after reset: lr_q still holds its
    // reset value there, so a channel change seen on it would be fictitious.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_SYNC;
            lr_q        <= 1'b1;
            lr_valid    <= 1'b0;
            prev_ch     <= 1'b0;
            shift_reg   <= 32'd0;
            hold_l      <= 32'd0;
            bit_cnt     <= 6'd0;
            audio_out_L <= 32'd0;
            audio_out_R <= 32'd0;
            audio_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            frame_error <= 1'b0;
            if (bit_ev) begin
                lr_q     <= ev_lr;
                lr_valid <= 1'b1;
                if (lr_valid) begin
                    prev_ch <= lr_q;
                    if (lr_q != prev_ch) begin
                        // Channel change: this bit is the MSB of a new word.
                        shift_reg <= {ev_sd, 31'd0};
                        bit_cnt   <= 6'd1;
                        case (state)
                            ST_SYNC: begin
                                if (!lr_q) state <= ST_LEFT;
                            end
                            ST_LEFT: begin
                                if (lr_q) begin
                                    hold_l      <= shift_reg;
                                    frame_error <= bad_count;
                                    state       <= ST_RIGHT;
                                end
                            end
                            ST_RIGHT: begin
                                if (!lr_q) begin
                                    audio_out_L <= hold_l;
                                    audio_out_R <= shift_reg;
                                    audio_valid <= 1'b1;
                                    frame_error <= bad_count;
                                    state       <= ST_LEFT;
                                end
                            end
                            default: state <= ST_SYNC;
                        endcase
                    end else begin
                        if (bit_cnt < 6'(SAMPLE_BITS))
                            shift_reg <= shift_reg | ({31'd0, ev_sd} << bit_pos);
                        if (bit_cnt != 6'h3f)
                            bit_cnt <= bit_cnt + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: randomized I2S frames, scoreboard queue of expected pairs,
// independent monitor on audio_valid / frame_error.
module tb_i2s_audio_rx;

  localparam int SB = 24;

  logic        clock;
  logic        reset_n;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic [31:0] audio_out_L;
  logic [31:0] audio_out_R;
  logic        audio_valid;
  logic        frame_error;

  i2s_audio_rx #(.SAMPLE_BITS(SB)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .audio_out_L(audio_out_L),
    .audio_out_R(audio_out_R),
    .audio_valid(audio_valid),
    .frame_error(frame_error)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #1500000;
    $display("FAIL watchdog: run still going at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];  // {right_err, left, right}
  int errors = 0;
  int checks = 0;
  int lerr_exp = 0;
  int lerr_seen = 0;
  int lmsb_cyc = 0;
  logic mark_next = 1'b0;
  logic prev_d = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the first min(n, SB) word bits land MSB-first from bit 31; all else zero.
  function automatic logic [31:0] model(input logic [31:0] w, input int n);
    logic [31:0] v;
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    v = w << (32 - SB);
    if (n < 32) v = v & ~(ones >> n);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // One BCLK period (320 ns, 16 system clocks). SDATA carries the previously
  // queued bit, which gives the one-bit I2S delay relative to LRCK.
  task automatic push_bit(input logic lr, input logic d);
    i2s_bclk  = 1'b0;
    i2s_lrck  = lr;
    i2s_sdata = prev_d;
    #160;
    i2s_bclk = 1'b1;
    if (mark_next) begin
      lmsb_cyc  = cyc;
      mark_next = 1'b0;
    end
    #160;
    prev_d = d;
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] w, input int n);
    logic b;
    for (int k = 0; k < n; k++) begin
      b = (k < SB) ? w[SB-1-k] : 1'b0;
      push_bit(ch, b);
      if (k == 0 && ch == 1'b0) mark_next = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int nl, input int nr, input bit counted);
    send_slot(1'b0, l, nl);
    send_slot(1'b1, r, nr);
    if (counted) begin
      exp_q.push_back({(nr != SB), model(l, nl), model(r, nr)});
      if (nl != SB) lerr_exp++;
    end
  endtask

  task automatic send_random_frames(input int count);
    int lens[6];
    lens = '{16, 20, 24, 28, 24, 24};
    for (int i = 0; i < count; i++)
      send_frame($urandom() & 32'h00FF_FFFF, $urandom() & 32'h00FF_FFFF,
                 lens[$urandom_range(0, 5)], lens[$urandom_range(0, 5)], 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_L"}, audio_out_L, 32'd0);
    check({tag, "_R"}, audio_out_R, 32'd0);
    check({tag, "_valid"}, {31'd0, audio_valid}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_error}, 32'd0);
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clock);
    #5;
    reset_n   = 1'b1;
    prev_d    = 1'b0;
    lerr_exp  = 0;
    lerr_seen = 0;
  endtask

  // Closing left MSB strobes the last pending frame, then the queue must drain.
  task automatic finish_phase(input string tag);
    int i;
    push_bit(1'b0, 1'b0);
    mark_next = 1'b1;
    push_bit(1'b0, 1'b0);
    i = 0;
    while (i < 50 && exp_q.size() > 0) begin
      @(posedge clock);
      i++;
    end
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    check({tag, "_left_errs"}, lerr_seen, lerr_exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) check("valid_width", {31'd0, audio_valid}, 32'd0);
      if (audio_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: L=0x%08h R=0x%08h with no frame expected", audio_out_L, audio_out_R);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("out_L", audio_out_L, e[63:32]);
          check("out_R", audio_out_R, e[31:0]);
          check("ferr_right", {31'd0, frame_error}, {31'd0, e[64]});
          check("latency", cyc - lmsb_cyc, 32'd4);
        end
      end else if (frame_error) begin
        lerr_seen++;
      end
      prev_valid = audio_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b1;
    i2s_bclk  = 1'b0;
    i2s_lrck  = 1'b0;
    i2s_sdata = 1'b0;
    #3;

    // Phase A: stream starts inside a right word, then directed and random frames.
    reset_n = 1'b0;
    check_reset_outputs("reset_a");
    release_reset();
    for (int k = 0; k < 5; k++) push_bit(1'b1, $urandom_range(0, 1));
    send_frame(32'h123456, 32'hABCDEF, 24, 24, 1'b1);
    send_frame(32'h800000, 32'h7FFFFF, 24, 24, 1'b1);
    send_frame(32'hFFFFFF, 32'hFFFFFF, 24, 24, 1'b1);
    send_frame(32'hA5A500, 32'h5A5A00, 16, 16, 1'b1);
    send_frame(32'h123456, 32'hABCDEF, 24, 24, 1'b1);
    send_random_frames(8);
    finish_phase("phase_a");

    // Phase B: stream starts inside a left word; that word and its right partner are dropped.
    reset_n = 1'b0;
    check_reset_outputs("reset_b");
    release_reset();
    for (int k = 0; k < 7; k++) push_bit(1'b0, $urandom_range(0, 1));
    send_slot(1'b1, $urandom() & 32'h00FF_FFFF, 24);
    send_random_frames(3);
    finish_phase("phase_b");

    // Phase C: reset lands in the middle of a right word.
    reset_n = 1'b0;
    check_reset_outputs("reset_c0");
    release_reset();
    for (int k = 0; k < 5; k++) push_bit(1'b1, 1'b0);
    send_frame(32'h3C3C3C, 32'hC3C3C3, 24, 24, 1'b1);
    send_slot(1'b0, $urandom() & 32'h00FF_FFFF, 24);
    for (int k = 0; k < 10; k++) push_bit(1'b1, $urandom_range(0, 1));
    check("pre_reset_L", audio_out_L, 32'h3C3C3C00);
    reset_n = 1'b0;
    check_reset_outputs("reset_c");
    for (int k = 0; k < 4; k++) push_bit(1'b1, $urandom_range(0, 1));
    reset_n   = 1'b1;
    lerr_exp  = 0;
    lerr_seen = 0;
    for (int k = 0; k < 10; k++) push_bit(1'b1, $urandom_range(0, 1));
    send_random_frames(3);
    finish_phase("phase_c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
